mgmt_flash_arbiter: RTL

//   Shares the single mgmt SoC SPI-flash read engine between two requesters:
//   m0 = CPU instruction/data fetch, m1 = housekeeping/debug reader.

---
 rtl/mgmt_flash_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mgmt_flash_arbiter.sv
// mgmt_flash_arbiter: two-requester arbiter for the single mgmt SPI-flash read engine.
// Optional timeout/abort path enabled by defining MGMT_FLASH_ARB_TIMEOUT_EN.
module mgmt_flash_arbiter #(
    parameter int AW          = 24,
    parameter int DW          = 32,
    parameter int STARVE_MAX  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic          core_clk,
    input  logic          RST,
    input  logic          m0_req_valid,
    output logic          m0_req_ready,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_rsp_valid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,
    input  logic          m1_req_valid,
    output logic          m1_req_ready,
    input  logic [AW-1:0] m1_addr,
    output logic          m1_rsp_valid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,
    output logic          f_req_valid,
    input  logic          f_req_ready,
    output logic [AW-1:0] f_addr,
    input  logic          f_rsp_valid,
    input  logic [DW-1:0] f_rdata,
    output logic          f_abort,
    output logic          busy,
    output logic          owner
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic          m0_rsp_q, m0_rsp_d, m1_rsp_q, m1_rsp_d;
    logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic          idle, m0_win, m1_win, done, abort, fin;

    assign idle   = state_q == IDLE;
    assign m1_win = m1_req_valid && (starve_q == SW'(STARVE_MAX) || !m0_req_valid);
    assign m0_win = m0_req_valid && !m1_win;
    assign done   = state_q == WAIT && f_rsp_valid;
    assign fin    = done || abort;

`ifdef MGMT_FLASH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    // Completion in the expiry cycle takes precedence over the abort.
    assign abort = !idle && tmo_q == TW'(TIMEOUT_CYC - 1) && !done;
    assign tmo_d = idle ? '0 : tmo_q + 1'b1;
    always_ff @(posedge core_clk or posedge RST)
        if (RST) tmo_q <= '0;
        else tmo_q <= tmo_d;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        owner_d = owner_q;
        if (idle && (m0_win || m1_win)) begin
            state_d = ISSUE;
            addr_d  = m1_win ? m1_addr : m0_addr;
            owner_d = m1_win;
        end else if (fin) state_d = IDLE;
        else if (state_q == ISSUE && f_req_ready) state_d = WAIT;
        starve_d   = m1_req_ready ? '0 :
                     (m1_req_valid && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
        m0_rsp_d   = fin && !owner_q;
        m1_rsp_d   = fin && owner_q;
        m0_err_d   = abort && !owner_q;
        m1_err_d   = abort && owner_q;
        m0_rdata_d = m0_rsp_d ? (abort ? {DW{1'b1}} : f_rdata) : m0_rdata_q;
        m1_rdata_d = m1_rsp_d ? (abort ? {DW{1'b1}} : f_rdata) : m1_rdata_q;
    end

    always_ff @(posedge core_clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            owner_q    <= 1'b0;
            starve_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_rsp_q   <= 1'b0;
            m1_rsp_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_rsp_q   <= m0_rsp_d;
            m1_rsp_q   <= m1_rsp_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
        end
    end

    assign m0_req_ready = idle && m0_win;
    assign m1_req_ready = idle && m1_win;
    assign m0_rsp_valid = m0_rsp_q;
    assign m1_rsp_valid = m1_rsp_q;
    assign m0_rdata     = m0_rdata_q;
    assign m1_rdata     = m1_rdata_q;
    assign m0_err       = m0_err_q;
    assign m1_err       = m1_err_q;
    assign f_req_valid  = state_q == ISSUE;
    assign f_addr       = addr_q;
    assign f_abort      = abort;
    assign busy         = !idle;
    assign owner        = owner_q;
endmodule
